// File: rtl/vga_ctrl_regs_pkg.sv
// Shared types and constants for the vga_control AXI4-Lite register slice.
// Register map, response codes, FSM state types and the register array type.
package vga_ctrl_regs_pkg;

    localparam int REG_COUNT = 4;
    localparam int REG_WIDTH = 32;

    localparam logic [1:0] CTRL   = 2'd0;
    localparam logic [1:0] PADDLE = 2'd1;
    localparam logic [1:0] BALL   = 2'd2;
    localparam logic [1:0] SCORE  = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        W_IDLE,
        W_HAVE_ADDR,
        W_HAVE_DATA,
        W_COMMIT,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    typedef logic [REG_COUNT-1:0][REG_WIDTH-1:0] reg_array_t;

endpackage

// File: rtl/vga_ctrl_strb_merge.sv
// Byte-strobe merge: each byte lane takes the new write data when its strobe
// is set, otherwise keeps the old register contents.
module vga_ctrl_strb_merge
    import vga_ctrl_regs_pkg::*;
(
    input  logic [REG_WIDTH-1:0]   i_old,
    input  logic [REG_WIDTH-1:0]   i_wdata,
    input  logic [REG_WIDTH/8-1:0] i_strb,
    output logic [REG_WIDTH-1:0]   o_merged
);

    for (genvar k = 0; k < REG_WIDTH/8; k++) begin : g_lane
        assign o_merged[8*k +: 8] = i_strb[k] ? i_wdata[8*k +: 8] : i_old[8*k +: 8];
    end

endmodule

// File: rtl/vga_ctrl_axil_regs.sv
// AXI4-Lite slave holding the four vga_control software registers, with
// shadow copies that only update on frame_start for tear-free game logic.
module vga_ctrl_axil_regs
    import vga_ctrl_regs_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_REGS           = 4
) (
    input  logic                                         S_AXI_ACLK,
    input  logic                                         S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]                S_AXI_AWADDR,
    input  logic [2:0]                                   S_AXI_AWPROT,
    input  logic                                         S_AXI_AWVALID,
    output logic                                         S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]                S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]              S_AXI_WSTRB,
    input  logic                                         S_AXI_WVALID,
    output logic                                         S_AXI_WREADY,
    output logic [1:0]                                   S_AXI_BRESP,
    output logic                                         S_AXI_BVALID,
    input  logic                                         S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]                S_AXI_ARADDR,
    input  logic [2:0]                                   S_AXI_ARPROT,
    input  logic                                         S_AXI_ARVALID,
    output logic                                         S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]                S_AXI_RDATA,
    output logic [1:0]                                   S_AXI_RRESP,
    output logic                                         S_AXI_RVALID,
    input  logic                                         S_AXI_RREADY,
    input  logic                                         frame_start,
    output logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0]  shadow_regs,
    output logic [NUM_REGS-1:0]                          reg_wr_pulse
);

    wr_state_t                         r_wstate;
    rd_state_t                         r_rstate;
    logic [C_S_AXI_ADDR_WIDTH-1:0]     r_awaddr;
    logic [REG_WIDTH-1:0]              r_wdata;
    logic [REG_WIDTH/8-1:0]            r_wstrb;
    logic                              r_awready;
    logic                              r_wready;
    logic                              r_bvalid;
    logic [1:0]                        r_bresp;
    logic                              r_arready;
    logic                              r_rvalid;
    logic [1:0]                        r_rresp;
    logic [REG_WIDTH-1:0]              r_rdata;
    reg_array_t                        r_regs;
    reg_array_t                        r_shadow;
    logic [REG_COUNT-1:0]              r_wr_pulse;

    logic                              w_aw_hs;
    logic                              w_w_hs;
    logic                              w_ar_hs;
    logic [1:0]                        w_wr_idx;
    logic [1:0]                        w_ar_idx;
    logic                              w_wr_err;
    logic                              w_ar_err;
    logic [REG_WIDTH-1:0]              w_merged;
    logic                              w_unused;

    assign w_aw_hs  = S_AXI_AWVALID && r_awready;
    assign w_w_hs   = S_AXI_WVALID && r_wready;
    assign w_ar_hs  = S_AXI_ARVALID && r_arready;
    assign w_wr_idx = r_awaddr[3:2];
    assign w_ar_idx = S_AXI_ARADDR[3:2];

    // Any address bit above the 16-byte register window selects nothing.
    assign w_wr_err = |(r_awaddr >> 4);
    assign w_ar_err = |(S_AXI_ARADDR >> 4);

    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, r_awaddr[1:0], S_AXI_ARADDR[1:0]};

    vga_ctrl_strb_merge u_strb_merge (
        .i_old    (r_regs[w_wr_idx]),
        .i_wdata  (r_wdata),
        .i_strb   (r_wstrb),
        .o_merged (w_merged)
    );

    // Write FSM: AW and W are captured independently; readies are registered
    // so they first rise on the clock edge after reset release.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_wstate  <= W_IDLE;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    r_awready <= 1'b1;
                    r_wready  <= 1'b1;
                    if (w_aw_hs) begin
                        r_awaddr <= S_AXI_AWADDR;
                    end
                    if (w_w_hs) begin
                        r_wdata <= S_AXI_WDATA;
                        r_wstrb <= S_AXI_WSTRB;
                    end
                    if (w_aw_hs && w_w_hs) begin
                        r_wstate  <= W_COMMIT;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                    end else if (w_aw_hs) begin
                        r_wstate  <= W_HAVE_ADDR;
                        r_awready <= 1'b0;
                    end else if (w_w_hs) begin
                        r_wstate <= W_HAVE_DATA;
                        r_wready <= 1'b0;
                    end
                end
                W_HAVE_ADDR: begin
                    if (w_w_hs) begin
                        r_wdata  <= S_AXI_WDATA;
                        r_wstrb  <= S_AXI_WSTRB;
                        r_wready <= 1'b0;
                        r_wstate <= W_COMMIT;
                    end
                end
                W_HAVE_DATA: begin
                    if (w_aw_hs) begin
                        r_awaddr  <= S_AXI_AWADDR;
                        r_awready <= 1'b0;
                        r_wstate  <= W_COMMIT;
                    end
                end
                W_COMMIT: begin
                    r_bvalid <= 1'b1;
                    r_bresp  <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
                    r_wstate <= W_RESP;
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: begin
                    r_wstate <= W_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_regs     <= '0;
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            if ((r_wstate == W_COMMIT) && !w_wr_err) begin
                r_regs[w_wr_idx]     <= w_merged;
                r_wr_pulse[w_wr_idx] <= 1'b1;
            end
        end
    end

    // Shadows sample the pre-commit value when a commit lands on frame_start.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_shadow <= '0;
        end else if (frame_start) begin
            r_shadow <= r_regs;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    r_arready <= 1'b1;
                    if (w_ar_hs) begin
                        r_rdata   <= w_ar_err ? '0 : r_regs[w_ar_idx];
                        r_rresp   <= w_ar_err ? RESP_SLVERR : RESP_OKAY;
                        r_rvalid  <= 1'b1;
                        r_arready <= 1'b0;
                        r_rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
                default: begin
                    r_rstate <= R_IDLE;
                end
            endcase
        end
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RDATA   = r_rdata;
    assign shadow_regs   = r_shadow;
    assign reg_wr_pulse  = r_wr_pulse;

endmodule

// File: tb/tb_vga_ctrl_axil_regs.sv
// Self-checking bench for vga_ctrl_axil_regs (6-bit address so that the
// out-of-window SLVERR path is reachable), using a register/shadow model.
module tb_vga_ctrl_axil_regs;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [AW-1:0] awaddr = '0;
    logic [2:0]    awprot = '0;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [31:0]   wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready = 1'b0;
    logic [AW-1:0] araddr = '0;
    logic [2:0]    arprot = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready = 1'b0;
    logic          frame_start = 1'b0;
    logic [3:0][31:0] shadow_regs;
    logic [3:0]    reg_wr_pulse;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs   [4];
    logic [31:0] m_shadow [4];

    always #5 clk = ~clk;

    vga_ctrl_axil_regs #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (AW),
        .NUM_REGS           (4)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .frame_start   (frame_start),
        .shadow_regs   (shadow_regs),
        .reg_wr_pulse  (reg_wr_pulse)
    );

    function automatic bit addr_bad(input logic [AW-1:0] a);
        return a[AW-1:4] != '0;
    endfunction

    task automatic model_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        if (!addr_bad(a)) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) m_regs[a[3:2]][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    task automatic model_frame();
        for (int i = 0; i < 4; i++) m_shadow[i] = m_regs[i];
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_regs[i]   = '0;
            m_shadow[i] = '0;
        end
    endtask

    function automatic logic [1:0] exp_resp(input logic [AW-1:0] a);
        return addr_bad(a) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [3:0] exp_pulse(input logic [AW-1:0] a);
        return addr_bad(a) ? 4'b0000 : (4'b0001 << a[3:2]);
    endfunction

    // AW and W offered together; lat counts negedges from handshake to BVALID.
    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output logic [3:0] pulse, output int lat);
        bit aw_done, w_done, aw_now, w_now;
        int cyc;
        @(negedge clk);
        awaddr = a; awvalid = 1'b1;
        wdata = d; wstrb = s; wvalid = 1'b1;
        bready = 1'b1;
        aw_done = 0; w_done = 0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 50) begin
            aw_now = awvalid && awready;
            w_now  = wvalid && wready;
            @(negedge clk);
            cyc++;
            if (aw_now) begin awvalid = 1'b0; aw_done = 1; end
            if (w_now)  begin wvalid = 1'b0;  w_done = 1;  end
        end
        lat = 0;
        while (!bvalid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        resp  = bresp;
        pulse = reg_wr_pulse;
        checks++;
        if (!(aw_done && w_done && bvalid)) begin
            errors++;
            $display("[TB] FAIL write_timeout: addr %h got done=%0b bvalid=%0b expected both 1", a, aw_done && w_done, bvalid);
        end
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp,
                            output int lat);
        int cyc;
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        cyc = 0;
        while (!arready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        arvalid = 1'b0;
        lat = 1;
        while (!rvalid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        d = rdata; resp = rresp;
        checks++;
        if (!rvalid) begin
            errors++;
            $display("[TB] FAIL read_timeout: addr %h got rvalid=0 expected 1", a);
        end
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic check_shadows(input string tag);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (shadow_regs[i] !== m_shadow[i]) begin
                errors++;
                $display("[TB] FAIL %s_shadow%0d: got %h expected %h", tag, i, shadow_regs[i], m_shadow[i]);
            end
        end
    endtask

    task automatic pulse_frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        model_frame();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({awready, wready, bvalid, arready, rvalid, bresp, rresp, reg_wr_pulse} !== '0 || rdata !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got aw%b w%b b%b ar%b r%b rdata %h expected all 0",
                     awready, wready, bvalid, arready, rvalid, rdata);
        end
        check_shadows("reset");
        rst_n = 1'b1;
        #1;
        checks++;
        if (awready !== 1'b0 || arready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ready_after_release: got aw%b ar%b expected 0 0", awready, arready);
        end
        @(negedge clk);
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errors++;
            $display("[TB] FAIL ready_first_edge: got %b expected 111", {awready, wready, arready});
        end
    endtask

    task automatic test_basic();
        logic [1:0] resp; logic [3:0] pulse; logic [31:0] d; int lat;
        for (int i = 0; i < 4; i++) begin
            axi_write(AW'(4*i), 32'(i + 1), 4'hF, resp, pulse, lat);
            model_write(AW'(4*i), 32'(i + 1), 4'hF);
            checks++;
            if (resp !== 2'b00 || pulse !== (4'b0001 << i) || lat != 1) begin
                errors++;
                $display("[TB] FAIL basic_write%0d: got resp %b pulse %b lat %0d expected 00 %b 1", i, resp, pulse, lat, 4'b0001 << i);
            end
            checks++;
            if (reg_wr_pulse !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL basic_pulse_width%0d: got %b expected 0000", i, reg_wr_pulse);
            end
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(AW'(4*i), d, resp, lat);
            checks++;
            if (d !== 32'(i + 1) || resp !== 2'b00 || lat != 1) begin
                errors++;
                $display("[TB] FAIL basic_read%0d: got %h resp %b lat %0d expected %h 00 1", i, d, resp, lat, i + 1);
            end
        end
    endtask

    task automatic test_strobe();
        logic [1:0] resp; logic [3:0] pulse; logic [31:0] d; int lat;
        axi_write(6'h04, 32'hAABBCCDD, 4'hF, resp, pulse, lat);
        model_write(6'h04, 32'hAABBCCDD, 4'hF);
        axi_write(6'h04, 32'h11223344, 4'h5, resp, pulse, lat);
        model_write(6'h04, 32'h11223344, 4'h5);
        axi_read(6'h04, d, resp, lat);
        checks++;
        if (d !== 32'hAA22CC44 || d !== m_regs[1]) begin
            errors++;
            $display("[TB] FAIL strobe_merge: got %h expected %h", d, 32'hAA22CC44);
        end
        axi_write(6'h07, 32'hFFFFFFFF, 4'h0, resp, pulse, lat);
        model_write(6'h07, 32'hFFFFFFFF, 4'h0);
        checks++;
        if (pulse !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL strobe_zero_pulse: got %b expected 0010", pulse);
        end
        axi_read(6'h04, d, resp, lat);
        checks++;
        if (d !== m_regs[1]) begin
            errors++;
            $display("[TB] FAIL strobe_zero_keep: got %h expected %h", d, m_regs[1]);
        end
    endtask

    task automatic test_w_before_aw();
        int cyc;
        @(negedge clk);
        wdata = 32'hCAFE0001; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
        checks++;
        if (wready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wfirst_wready: got %b expected 1", wready);
        end
        @(negedge clk);
        wvalid = 1'b0;
        checks++;
        if (wready !== 1'b0 || awready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wfirst_after_w: got wready %b awready %b expected 0 1", wready, awready);
        end
        repeat (2) @(negedge clk);
        awaddr = 6'h0C; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        model_write(6'h0C, 32'hCAFE0001, 4'hF);
        checks++;
        if (bvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wfirst_bvalid_early: got %b expected 0", bvalid);
        end
        @(negedge clk);
        checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b00 || reg_wr_pulse !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL wfirst_bvalid: got bvalid %b bresp %b pulse %b expected 1 00 1000", bvalid, bresp, reg_wr_pulse);
        end
        awaddr = 6'h00; awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bvalid !== 1'b1 || awready !== 1'b0 || reg_wr_pulse !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL wfirst_hold%0d: got bvalid %b awready %b pulse %b expected 1 0 0000", i, bvalid, awready, reg_wr_pulse);
            end
        end
        bready = 1'b1;
        @(negedge clk);
        checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wfirst_release: got bvalid %b awready %b expected 0 1", bvalid, awready);
        end
        @(negedge clk);
        awvalid = 1'b0;
        wdata = 32'h0BADF00D; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        model_write(6'h00, 32'h0BADF00D, 4'hF);
        cyc = 0;
        while (!bvalid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (bvalid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wfirst_second_b: got bvalid %b expected 1", bvalid);
        end
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic test_shadow();
        logic [1:0] resp; logic [3:0] pulse; int lat;
        axi_write(6'h08, 32'h00000055, 4'hF, resp, pulse, lat);
        model_write(6'h08, 32'h00000055, 4'hF);
        check_shadows("pre_frame");
        pulse_frame();
        check_shadows("post_frame");
        @(negedge clk);
        awaddr = 6'h08; awvalid = 1'b1; wdata = 32'h00000077; wstrb = 4'hF; wvalid = 1'b1;
        bready = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        frame_start = 1'b1;
        araddr = 6'h08; arvalid = 1'b1; rready = 1'b1;
        model_frame();
        checks++;
        if (arready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL coincide_arready: got %b expected 1", arready);
        end
        @(negedge clk);
        frame_start = 1'b0; arvalid = 1'b0;
        checks++;
        if (rvalid !== 1'b1 || rdata !== m_regs[2]) begin
            errors++;
            $display("[TB] FAIL read_vs_commit: got rvalid %b rdata %h expected 1 %h", rvalid, rdata, m_regs[2]);
        end
        model_write(6'h08, 32'h00000077, 4'hF);
        check_shadows("coincide");
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;
        pulse_frame();
        check_shadows("after_coincide");
    endtask

    task automatic test_slverr();
        logic [1:0] resp; logic [3:0] pulse; logic [31:0] d; int lat;
        axi_write(6'h10, 32'h000000FF, 4'hF, resp, pulse, lat);
        checks++;
        if (resp !== 2'b10 || pulse !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL slverr_write: got resp %b pulse %b expected 10 0000", resp, pulse);
        end
        axi_read(6'h10, d, resp, lat);
        checks++;
        if (resp !== 2'b10 || d !== 32'h0) begin
            errors++;
            $display("[TB] FAIL slverr_read: got resp %b data %h expected 10 00000000", resp, d);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(AW'(4*i), d, resp, lat);
            checks++;
            if (d !== m_regs[i] || resp !== 2'b00) begin
                errors++;
                $display("[TB] FAIL slverr_unchanged%0d: got %h expected %h", i, d, m_regs[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] resp; logic [3:0] pulse; logic [31:0] d; int lat;
        logic [AW-1:0] a; logic [31:0] dat; logic [3:0] s;
        for (int n = 0; n < 60; n++) begin
            a[3:0] = 4'($urandom_range(0, 15));
            a[5:4] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            case ($urandom_range(0, 4))
                0, 1: begin
                    dat = $urandom;
                    s   = 4'($urandom_range(0, 15));
                    axi_write(a, dat, s, resp, pulse, lat);
                    model_write(a, dat, s);
                    checks++;
                    if (resp !== exp_resp(a) || pulse !== exp_pulse(a) || lat != 1) begin
                        errors++;
                        $display("[TB] FAIL rand_write%0d: addr %h got resp %b pulse %b lat %0d expected %b %b 1",
                                 n, a, resp, pulse, lat, exp_resp(a), exp_pulse(a));
                    end
                end
                2, 3: begin
                    axi_read(a, d, resp, lat);
                    checks++;
                    if (resp !== exp_resp(a) || d !== (addr_bad(a) ? 32'h0 : m_regs[a[3:2]])) begin
                        errors++;
                        $display("[TB] FAIL rand_read%0d: addr %h got %h resp %b expected %h %b",
                                 n, a, d, resp, addr_bad(a) ? 32'h0 : m_regs[a[3:2]], exp_resp(a));
                    end
                end
                default: begin
                    pulse_frame();
                    check_shadows("rand");
                end
            endcase
        end
    endtask

    task automatic test_reset_midflight();
        logic [1:0] resp; logic [3:0] pulse; logic [31:0] d; int lat;
        @(negedge clk);
        awaddr = 6'h04; awvalid = 1'b1; wdata = 32'h00001234; wstrb = 4'hF; wvalid = 1'b1;
        araddr = 6'h00; arvalid = 1'b1;
        bready = 1'b0; rready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bvalid !== 1'b1 || rvalid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midflight_setup: got bvalid %b rvalid %b expected 1 1", bvalid, rvalid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({awready, wready, bvalid, arready, rvalid, bresp, rresp, reg_wr_pulse} !== '0 || rdata !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset: got aw%b w%b b%b ar%b r%b expected all 0", awready, wready, bvalid, arready, rvalid);
        end
        check_shadows("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            axi_read(AW'(4*i), d, resp, lat);
            checks++;
            if (d !== m_regs[i]) begin
                errors++;
                $display("[TB] FAIL reset_regs%0d: got %h expected %h", i, d, m_regs[i]);
            end
        end
        axi_write(6'h00, 32'h9, 4'hF, resp, pulse, lat);
        model_write(6'h00, 32'h9, 4'hF);
        axi_read(6'h00, d, resp, lat);
        checks++;
        if (d !== 32'h9 || resp !== 2'b00) begin
            errors++;
            $display("[TB] FAIL post_reset_rw: got %h resp %b expected 00000009 00", d, resp);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #2;
        test_reset();
        test_basic();
        test_strobe();
        test_w_before_aw();
        test_shadow();
        test_slverr();
        test_random();
        test_reset_midflight();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
